sram_stage_sequencer: RTL and testbench

- Top-level scheduler for the image decompressor.
- Runs the SRAM-bound stages in a fixed order: UART image load, then M2 (IDCT/dequant), then M1 (upsample + colour-space convert).
- Shares the single external SRAM port between the three stage requesters, with an enforced idle handoff gap.
- Reports progress, completion and stall errors to the board top level.

---
 rtl/sram_stage_sequencer_pkg.sv | 45 ++++
 rtl/sram_stage_sequencer_if.sv | 36 +++
 rtl/sram_stage_sequencer_sram_port_mux.sv | 47 ++++
 rtl/sram_stage_sequencer.sv | 149 ++++++++++++++
 tb/tb_sram_stage_sequencer.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/sram_stage_sequencer_pkg.sv
// Shared types for the decompressor stage sequencer.
// Holds the sequencer state set, the stage codes reported on active_stage,
// the SRAM bus widths, and helpers that map states to stages.
package sram_stage_sequencer_pkg;

    localparam int unsigned ADDR_W = 18;
    localparam int unsigned DATA_W = 16;

    typedef enum logic [2:0] {
        S_SEQ_IDLE,
        S_SEQ_UART,
        S_SEQ_GAP,
        S_SEQ_M2,
        S_SEQ_M1,
        S_SEQ_DONE,
        S_SEQ_ERROR
    } seq_state_type;

    typedef enum logic [1:0] {
        STAGE_NONE = 2'd0,
        STAGE_UART = 2'd1,
        STAGE_M2   = 2'd2,
        STAGE_M1   = 2'd3
    } stage_type;

    // Stage that owns the SRAM port while the sequencer sits in state s.
    function automatic stage_type stage_of(input seq_state_type s);
        case (s)
            S_SEQ_UART: return STAGE_UART;
            S_SEQ_M2:   return STAGE_M2;
            S_SEQ_M1:   return STAGE_M1;
            default:    return STAGE_NONE;
        endcase
    endfunction

    // State entered once the handoff gap that follows stage st has elapsed.
    function automatic seq_state_type stage_after(input stage_type st);
        case (st)
            STAGE_UART: return S_SEQ_M2;
            STAGE_M2:   return S_SEQ_M1;
            default:    return S_SEQ_DONE;
        endcase
    endfunction

endpackage

// File: rtl/sram_stage_sequencer_if.sv
// Stage requester / SRAM bus bundle for the stage sequencer.
// Carries each requester's address, write data, write enable and done pulse,
// the per-stage enables, and the single muxed SRAM port.
//   master : sequencer side (drives enables and the SRAM port)
//   slave  : requester / board side (drives requests and done pulses)
interface sram_stage_sequencer_if;
    import sram_stage_sequencer_pkg::*;

    logic [ADDR_W-1:0] uart_addr, m2_addr, m1_addr;
    logic [DATA_W-1:0] uart_wdata, m2_wdata, m1_wdata;
    logic              uart_we_n, m2_we_n, m1_we_n;
    logic              uart_done, m2_done, m1_done;
    logic              uart_enable, m2_enable, m1_enable;
    logic [ADDR_W-1:0] SRAM_address;
    logic [DATA_W-1:0] SRAM_write_data;
    logic              SRAM_we_n;

    modport master (
        input  uart_addr, m2_addr, m1_addr,
        input  uart_wdata, m2_wdata, m1_wdata,
        input  uart_we_n, m2_we_n, m1_we_n,
        input  uart_done, m2_done, m1_done,
        output uart_enable, m2_enable, m1_enable,
        output SRAM_address, SRAM_write_data, SRAM_we_n
    );

    modport slave (
        output uart_addr, m2_addr, m1_addr,
        output uart_wdata, m2_wdata, m1_wdata,
        output uart_we_n, m2_we_n, m1_we_n,
        output uart_done, m2_done, m1_done,
        input  uart_enable, m2_enable, m1_enable,
        input  SRAM_address, SRAM_write_data, SRAM_we_n
    );

endinterface

// File: rtl/sram_stage_sequencer_sram_port_mux.sv
// Combinational 3:1 SRAM port mux.
// Ports: sel (owning stage), per-requester addr/wdata/we_n in,
//        SRAM_address / SRAM_write_data / SRAM_we_n out.
// With no owner the port is parked: address 0, data 0, write disabled.
module sram_port_mux
    import sram_stage_sequencer_pkg::*;
(
    input  stage_type         sel,
    input  logic [ADDR_W-1:0] uart_addr,
    input  logic [DATA_W-1:0] uart_wdata,
    input  logic              uart_we_n,
    input  logic [ADDR_W-1:0] m2_addr,
    input  logic [DATA_W-1:0] m2_wdata,
    input  logic              m2_we_n,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_we_n,
    output logic [ADDR_W-1:0] SRAM_address,
    output logic [DATA_W-1:0] SRAM_write_data,
    output logic              SRAM_we_n
);

    always_comb begin
        SRAM_address    = '0;
        SRAM_write_data = '0;
        SRAM_we_n       = 1'b1;
        case (sel)
            STAGE_UART: begin
                SRAM_address    = uart_addr;
                SRAM_write_data = uart_wdata;
                SRAM_we_n       = uart_we_n;
            end
            STAGE_M2: begin
                SRAM_address    = m2_addr;
                SRAM_write_data = m2_wdata;
                SRAM_we_n       = m2_we_n;
            end
            STAGE_M1: begin
                SRAM_address    = m1_addr;
                SRAM_write_data = m1_wdata;
                SRAM_we_n       = m1_we_n;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sram_stage_sequencer.sv
// Top-level stage scheduler for the image decompressor.
// Runs UART load -> M2 -> M1, hands the single SRAM port to one stage at a
// time with an idle gap between owners, and guards each stage with a watchdog.
// Ports:
//   Clock, Resetn           clock, synchronous active-low reset
//   start, skip_load        run request pulse; skip_load picks M2 as first stage
//   soft_abort              abandon the run and return to idle
//   bus (master)            requester inputs, stage enables, muxed SRAM port
//   active_stage            0 none, 1 UART, 2 M2, 3 M1
//   busy, done, error       run in progress, completion pulse, sticky watchdog flag
module sram_stage_sequencer
    import sram_stage_sequencer_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 2,
    parameter int unsigned TIMEOUT_W  = 24
) (
    input  logic                          Clock,
    input  logic                          Resetn,
    input  logic                          start,
    input  logic                          skip_load,
    input  logic                          soft_abort,
    sram_stage_sequencer_if.master        bus,
    output logic [1:0]                    active_stage,
    output logic                          busy,
    output logic                          done,
    output logic                          error
);

    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_HANDOFF = GAP_W'(GAP_CYCLES);
    localparam logic [GAP_W-1:0] GAP_FINAL   = GAP_W'(GAP_CYCLES - 1);
    // Timeout fires in the cycle the counter would step onto all-ones.
    localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    seq_state_type          state, next_state;
    stage_type              active_stage_q, last_stage_q;
    logic [TIMEOUT_W-1:0]   wd_q;
    logic [GAP_W-1:0]       gap_cnt_q;
    logic [GAP_W-1:0]       gap_limit;
    logic                   wd_expired;
    logic                   run_start;
    logic                   done_q;
    logic                   error_q;

    assign wd_expired = (wd_q == WD_LAST);

    // Handing the port to another stage keeps one extra release cycle after
    // the outgoing enable drops; the last stage goes straight to DONE.
    assign gap_limit = (stage_after(last_stage_q) == S_SEQ_DONE) ? GAP_FINAL : GAP_HANDOFF;

    // State register and counters
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state          <= S_SEQ_IDLE;
            active_stage_q <= STAGE_NONE;
            last_stage_q   <= STAGE_NONE;
            wd_q           <= '0;
            gap_cnt_q      <= '0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state          <= next_state;
            active_stage_q <= stage_of(next_state);
            done_q         <= (next_state == S_SEQ_DONE) && (state != S_SEQ_DONE);

            if (stage_of(next_state) != STAGE_NONE && next_state != state)
                wd_q <= '0;
            else if (stage_of(state) != STAGE_NONE)
                wd_q <= wd_q + 1'b1;

            if (next_state == S_SEQ_GAP && state != S_SEQ_GAP) begin
                gap_cnt_q    <= '0;
                last_stage_q <= stage_of(state);
            end else if (state == S_SEQ_GAP && next_state == S_SEQ_GAP) begin
                gap_cnt_q <= gap_cnt_q + 1'b1;
            end

            if (run_start)
                error_q <= 1'b0;
            else if (next_state == S_SEQ_ERROR && state != S_SEQ_ERROR)
                error_q <= 1'b1;
        end
    end

    // Next-state logic; a stage's own done beats its watchdog expiry
    always_comb begin
        next_state = state;
        run_start  = 1'b0;
        if (soft_abort) begin
            if (state != S_SEQ_IDLE)
                next_state = S_SEQ_IDLE;
        end else begin
            case (state)
                S_SEQ_IDLE, S_SEQ_DONE, S_SEQ_ERROR: begin
                    if (start) begin
                        run_start  = 1'b1;
                        next_state = skip_load ? S_SEQ_M2 : S_SEQ_UART;
                    end
                end
                S_SEQ_UART: begin
                    if (bus.uart_done)    next_state = S_SEQ_GAP;
                    else if (wd_expired)  next_state = S_SEQ_ERROR;
                end
                S_SEQ_M2: begin
                    if (bus.m2_done)      next_state = S_SEQ_GAP;
                    else if (wd_expired)  next_state = S_SEQ_ERROR;
                end
                S_SEQ_M1: begin
                    if (bus.m1_done)      next_state = S_SEQ_GAP;
                    else if (wd_expired)  next_state = S_SEQ_ERROR;
                end
                S_SEQ_GAP: begin
                    if (gap_cnt_q == gap_limit)
                        next_state = stage_after(last_stage_q);
                end
                default: next_state = S_SEQ_IDLE;
            endcase
        end
    end

    // Outputs decoded from registered state
    always_comb begin
        bus.uart_enable = (active_stage_q == STAGE_UART);
        bus.m2_enable   = (active_stage_q == STAGE_M2);
        bus.m1_enable   = (active_stage_q == STAGE_M1);
        active_stage    = active_stage_q;
        busy            = (state == S_SEQ_UART) || (state == S_SEQ_GAP) ||
                          (state == S_SEQ_M2)   || (state == S_SEQ_M1);
        done            = done_q;
        error           = error_q;
    end

    sram_port_mux u_mux (
        .sel             (active_stage_q),
        .uart_addr       (bus.uart_addr),
        .uart_wdata      (bus.uart_wdata),
        .uart_we_n       (bus.uart_we_n),
        .m2_addr         (bus.m2_addr),
        .m2_wdata        (bus.m2_wdata),
        .m2_we_n         (bus.m2_we_n),
        .m1_addr         (bus.m1_addr),
        .m1_wdata        (bus.m1_wdata),
        .m1_we_n         (bus.m1_we_n),
        .SRAM_address    (bus.SRAM_address),
        .SRAM_write_data (bus.SRAM_write_data),
        .SRAM_we_n       (bus.SRAM_we_n)
    );

endmodule

// File: tb/tb_sram_stage_sequencer.sv
// Scoreboard bench for sram_stage_sequencer (GAP_CYCLES=2, TIMEOUT_W=8).
// Stimulus pushes hand-computed expectations; a monitor compares them.
module tb_sram_stage_sequencer;

    logic       Clock = 1'b0;
    logic       Resetn, start, skip_load, soft_abort;
    logic [1:0] active_stage;
    logic       busy, done, error;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    sram_stage_sequencer_if bus();

    sram_stage_sequencer #(.GAP_CYCLES(2), .TIMEOUT_W(8)) dut (
        .Clock        (Clock),
        .Resetn       (Resetn),
        .start        (start),
        .skip_load    (skip_load),
        .soft_abort   (soft_abort),
        .bus          (bus),
        .active_stage (active_stage),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    // Events: any change of {uart_en, m2_en, m1_en, busy, done, error}
    typedef struct { int cyc; logic [5:0] v; } ev_t;
    // Points: full output vector at a given cycle
    typedef struct { int cyc; logic [42:0] v; } pt_t;
    ev_t evq[$];
    pt_t ptq[$];

    function automatic logic [5:0] snap();
        return {bus.uart_enable, bus.m2_enable, bus.m1_enable, busy, done, error};
    endfunction

    function automatic logic [42:0] pvec(input logic [2:0] en, input logic b, input logic d,
                                         input logic e, input logic [1:0] st, input logic we,
                                         input logic [17:0] a, input logic [15:0] w);
        return {en, b, d, e, st, we, a, w};
    endfunction

    task automatic ev(input int c, input logic [5:0] v);
        ev_t x;
        x.cyc = c; x.v = v;
        evq.push_back(x);
    endtask

    task automatic pt(input int c, input logic [42:0] v);
        pt_t x;
        x.cyc = c; x.v = v;
        ptq.push_back(x);
    endtask

    task automatic at(input int n);
        while (cyc < n) @(negedge Clock);
    endtask

    // Monitor: samples 1 time unit after the falling edge
    initial begin : monitor
        logic [5:0]  cur, prev;
        logic [42:0] act;
        pt_t         p;
        ev_t         e;
        @(negedge Clock); #1;
        prev = snap();
        forever begin
            @(negedge Clock); #1;
            cur = snap();
            act = pvec({bus.uart_enable, bus.m2_enable, bus.m1_enable}, busy, done, error,
                       active_stage, bus.SRAM_we_n, bus.SRAM_address, bus.SRAM_write_data);
            while (ptq.size() > 0 && ptq[0].cyc <= cyc) begin
                p = ptq.pop_front();
                checks++;
                if (p.cyc != cyc || act !== p.v) begin
                    errors++;
                    $display("FAIL point@%0d: got %h at cycle %0d, required %h", p.cyc, act, cyc, p.v);
                end
            end
            if (cur !== prev) begin
                checks++;
                if (evq.size() == 0) begin
                    errors++;
                    $display("FAIL event: unexpected %b at cycle %0d, none required", cur, cyc);
                end else begin
                    e = evq.pop_front();
                    if (e.cyc != cyc || e.v !== cur) begin
                        errors++;
                        $display("FAIL event@%0d: got %b at cycle %0d, required %b", e.cyc, cur, cyc, e.v);
                    end
                end
            end else if (evq.size() > 0 && evq[0].cyc <= cyc) begin
                e = evq.pop_front();
                checks++;
                errors++;
                $display("FAIL event@%0d: outputs stayed %b, required %b", e.cyc, cur, e.v);
            end
            prev = cur;
        end
    end

    initial begin
        Resetn = 1'b0; start = 1'b0; skip_load = 1'b0; soft_abort = 1'b0;
        bus.uart_addr = 18'h11111; bus.uart_wdata = 16'hA1A1; bus.uart_we_n = 1'b0;
        bus.m2_addr   = 18'h22222; bus.m2_wdata   = 16'hB2B2; bus.m2_we_n   = 1'b0;
        bus.m1_addr   = 18'h33333; bus.m1_wdata   = 16'hC3C3; bus.m1_we_n   = 1'b0;
        bus.uart_done = 1'b0; bus.m2_done = 1'b0; bus.m1_done = 1'b0;

        // Reset: port parked even though every requester drives a write
        pt(2, pvec(3'b000, 0, 0, 0, 2'd0, 1'b1, 18'h0, 16'h0));
        at(3); Resetn = 1'b1;

        // Full run with stray done, mux isolation and start-while-busy
        ev(11,  6'b100100);
        ev(101, 6'b000100);
        ev(104, 6'b010100);
        ev(301, 6'b000100);
        ev(304, 6'b001100);
        ev(501, 6'b000100);
        ev(503, 6'b000010);
        ev(504, 6'b000000);
        pt(50,  pvec(3'b100, 1, 0, 0, 2'd1, 1'b0, 18'h11111, 16'hA1A1));
        pt(102, pvec(3'b000, 1, 0, 0, 2'd0, 1'b1, 18'h0, 16'h0));
        pt(103, pvec(3'b000, 1, 0, 0, 2'd0, 1'b1, 18'h0, 16'h0));
        pt(104, pvec(3'b010, 1, 0, 0, 2'd2, 1'b0, 18'h22222, 16'hB2B2));
        pt(220, pvec(3'b010, 1, 0, 0, 2'd2, 1'b1, 18'h22222, 16'hB2B2));
        pt(230, pvec(3'b010, 1, 0, 0, 2'd2, 1'b0, 18'h00ABC, 16'h1234));
        pt(400, pvec(3'b001, 1, 0, 0, 2'd3, 1'b0, 18'h33333, 16'hC3C3));
        pt(503, pvec(3'b000, 0, 1, 0, 2'd0, 1'b1, 18'h0, 16'h0));
        at(10);  start = 1'b1;
        at(11);  start = 1'b0;
        at(50);  bus.m1_done = 1'b1;
        at(51);  bus.m1_done = 1'b0;
        at(100); bus.uart_done = 1'b1;
        at(101); bus.uart_done = 1'b0;
        at(220); bus.uart_addr = 18'h3FFFF; bus.m2_we_n = 1'b1;
        at(230); bus.m2_addr = 18'h00ABC; bus.m2_wdata = 16'h1234; bus.m2_we_n = 1'b0;
        at(240); bus.m2_addr = 18'h22222; bus.m2_wdata = 16'hB2B2; bus.uart_addr = 18'h11111;
        at(250); start = 1'b1; skip_load = 1'b1;
        at(251); start = 1'b0; skip_load = 1'b0;
        at(260); bus.uart_done = 1'b1;
        at(261); bus.uart_done = 1'b0;
        at(300); bus.m2_done = 1'b1;
        at(301); bus.m2_done = 1'b0;
        at(500); bus.m1_done = 1'b1;
        at(501); bus.m1_done = 1'b0;

        // soft_abort in M1, then abort+start together while idle
        ev(601, 6'b010100);
        ev(611, 6'b000100);
        ev(614, 6'b001100);
        ev(621, 6'b000000);
        pt(620, pvec(3'b001, 1, 0, 0, 2'd3, 1'b0, 18'h33333, 16'hC3C3));
        pt(621, pvec(3'b000, 0, 0, 0, 2'd0, 1'b1, 18'h0, 16'h0));
        at(600); start = 1'b1; skip_load = 1'b1;
        at(601); start = 1'b0; skip_load = 1'b0;
        at(610); bus.m2_done = 1'b1;
        at(611); bus.m2_done = 1'b0;
        at(620); soft_abort = 1'b1;
        at(621); soft_abort = 1'b0;
        at(630); soft_abort = 1'b1; start = 1'b1;
        at(631); soft_abort = 1'b0; start = 1'b0;

        // Reset in M1
        ev(641, 6'b010100);
        ev(651, 6'b000100);
        ev(654, 6'b001100);
        ev(661, 6'b000000);
        pt(661, pvec(3'b000, 0, 0, 0, 2'd0, 1'b1, 18'h0, 16'h0));
        at(640); start = 1'b1; skip_load = 1'b1;
        at(641); start = 1'b0; skip_load = 1'b0;
        at(650); bus.m2_done = 1'b1;
        at(651); bus.m2_done = 1'b0;
        at(660); Resetn = 1'b0;
        at(661); Resetn = 1'b1;

        // Watchdog expiry in M2 (255 enabled cycles), then a start clears error
        ev(701, 6'b010100);
        ev(956, 6'b000001);
        ev(981, 6'b100100);
        ev(991, 6'b000000);
        pt(955, pvec(3'b010, 1, 0, 0, 2'd2, 1'b0, 18'h22222, 16'hB2B2));
        pt(956, pvec(3'b000, 0, 0, 1, 2'd0, 1'b1, 18'h0, 16'h0));
        at(700); start = 1'b1; skip_load = 1'b1;
        at(701); start = 1'b0; skip_load = 1'b0;
        at(980); start = 1'b1;
        at(981); start = 1'b0;
        at(990); soft_abort = 1'b1;
        at(991); soft_abort = 1'b0;

        // done on the watchdog's last cycle wins; run completes normally
        ev(1001, 6'b010100);
        ev(1256, 6'b000100);
        ev(1259, 6'b001100);
        ev(1271, 6'b000100);
        ev(1273, 6'b000010);
        ev(1274, 6'b000000);
        at(1000); start = 1'b1; skip_load = 1'b1;
        at(1001); start = 1'b0; skip_load = 1'b0;
        at(1255); bus.m2_done = 1'b1;
        at(1256); bus.m2_done = 1'b0;
        at(1270); bus.m1_done = 1'b1;
        at(1271); bus.m1_done = 1'b0;

        at(1300);
        @(posedge Clock);
        while (evq.size() > 0) begin
            ev_t e;
            e = evq.pop_front();
            checks++; errors++;
            $display("FAIL event@%0d: never observed, required %b", e.cyc, e.v);
        end
        while (ptq.size() > 0) begin
            pt_t p;
            p = ptq.pop_front();
            checks++; errors++;
            $display("FAIL point@%0d: never sampled, required %h", p.cyc, p.v);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
